portsrc: RTL and testbench

Serial packet source for the router's input-port protocol: the transmit end paired with the per-port receiver. It accepts one 4-bit destination address plus a 32-bit payload over a ready/valid handshake and serializes it onto one input port's frame_n / valid_n / di lines. It is used in the router's self-test and loop-back paths and as the stimulus driver for port-level verification.

---
 rtl/portsrc.sv | 142 ++++++++++++++
 tb/tb_portsrc.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/portsrc.sv
// portsrc: serialises one {addr, payload} request onto a router input port
// as address bits, padding, then payload bits (stallable), followed by a gap.
`default_nettype none

module portsrc #(
  parameter int PAD_CYCLES = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        vld,
  input  logic [3:0]  addr,
  input  logic [31:0] payload,
  input  logic        stall,
  output logic        rdy,
  output logic        frame_n,
  output logic        valid_n,
  output logic        di
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    PAD  = 3'd2,
    DATA = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [5:0] PAD_LAST = 6'(PAD_CYCLES - 1);

  state_t      state, state_nx;
  logic [5:0]  cnt, cnt_nx;
  logic [3:0]  addr_q;
  logic [31:0] data_q;
  logic        frame_nx, valid_nx, di_nx;
  logic        load;
  logic [1:0]  addr_idx;
  logic [5:0]  bit_idx;

  assign rdy = (state == IDLE) && reset_n;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    frame_nx = frame_n;
    valid_nx = valid_n;
    di_nx    = di;
    load     = 1'b0;
    addr_idx = cnt[1:0] + 2'd1;
    // In DATA, cnt is the index of the next payload bit to send.
    bit_idx  = (state == DATA) ? cnt : 6'd0;

    case (state)
      IDLE: begin
        frame_nx = 1'b1;
        valid_nx = 1'b1;
        di_nx    = 1'b0;
        if (vld) begin
          load     = 1'b1;
          state_nx = ADDR;
          cnt_nx   = 6'd0;
          frame_nx = 1'b0;
          di_nx    = addr[0];
        end
      end
      ADDR: begin
        frame_nx = 1'b0;
        valid_nx = 1'b1;
        if (cnt == 6'd3) begin
          state_nx = PAD;
          cnt_nx   = 6'd0;
          di_nx    = 1'b1;
        end else begin
          cnt_nx = cnt + 6'd1;
          di_nx  = addr_q[addr_idx];
        end
      end
      PAD, DATA: begin
        if (state == PAD && cnt != PAD_LAST) begin
          cnt_nx = cnt + 6'd1;
          di_nx  = 1'b1;
        end else if (state == DATA && cnt == 6'd32) begin
          // bit 31 was on the wire; a stall sampled now is irrelevant
          state_nx = GAP;
          cnt_nx   = 6'd0;
          frame_nx = 1'b1;
          valid_nx = 1'b1;
          di_nx    = 1'b0;
        end else begin
          state_nx = DATA;
          frame_nx = 1'b0;
          if (stall) begin
            valid_nx = 1'b1;
            cnt_nx   = bit_idx;
          end else begin
            valid_nx = 1'b0;
            di_nx    = data_q[bit_idx[4:0]];
            frame_nx = (bit_idx == 6'd31);
            cnt_nx   = bit_idx + 6'd1;
          end
        end
      end
      GAP: begin
        state_nx = IDLE;
        frame_nx = 1'b1;
        valid_nx = 1'b1;
        di_nx    = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 6'd0;
        frame_nx = 1'b1;
        valid_nx = 1'b1;
        di_nx    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      frame_n <= 1'b1;
      valid_n <= 1'b1;
      di      <= 1'b0;
      addr_q  <= 4'd0;
      data_q  <= 32'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      frame_n <= frame_nx;
      valid_n <= valid_nx;
      di      <= di_nx;
      if (load) begin
        addr_q <= addr;
        data_q <= payload;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_portsrc.sv
// tb_portsrc: scoreboard bench for portsrc; expected wire activity is queued
// at request acceptance and compared cycle by cycle on the falling edge.
`default_nettype none

module tb_portsrc;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
    int          lo;
    int          hi;
    int          rise;
  } pkt_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        vld;
  logic [3:0]  addr;
  logic [31:0] payload;
  logic        stall;
  logic        rdy5, frame5, valid5, di5;
  logic        rdy1, frame1, valid1, di1;

  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  int          lo = -10;
  int          hi = -10;
  int          cur_rise = -1;
  bit          sel = 1'b0;
  bit          hold_vld = 1'b0;
  bit          prev_frame = 1'b1;
  logic [3:0]  exp_q[$];
  pkt_t        pkt_q[$];

  portsrc #(.PAD_CYCLES(5)) dut (
    .clock(clock), .reset_n(reset_n), .vld(vld), .addr(addr), .payload(payload),
    .stall(stall), .rdy(rdy5), .frame_n(frame5), .valid_n(valid5), .di(di5)
  );

  portsrc #(.PAD_CYCLES(1)) dut_pad1 (
    .clock(clock), .reset_n(reset_n), .vld(vld), .addr(addr), .payload(payload),
    .stall(stall), .rdy(rdy1), .frame_n(frame1), .valid_n(valid1), .di(di1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t k=%0d got=%h want=%h", tag, $time, k, got, want);
    end
  endtask

  function automatic logic [3:0] observe();
    return sel ? {rdy1, frame1, valid1, di1} : {rdy5, frame5, valid5, di5};
  endfunction

  // Expected {rdy, frame_n, valid_n, di} for cycles T+1 .. GAP.
  task automatic build(input pkt_t p);
    int   pad;
    int   b;
    int   c;
    logic last_di;
    pad = sel ? 1 : 5;
    for (int i = 0; i < 4; i++) exp_q.push_back({3'b001, p.a[i]});
    for (int i = 0; i < pad; i++) exp_q.push_back(4'b0011);
    b = 0;
    c = 5 + pad;
    last_di = 1'b1;
    while (b < 32) begin
      if ((c - 1) >= p.lo && (c - 1) <= p.hi) begin
        exp_q.push_back({3'b001, last_di});
      end else begin
        last_di = p.d[b];
        exp_q.push_back({1'b0, (b == 31), 1'b0, last_di});
        b++;
      end
      c++;
    end
    exp_q.push_back(4'b0110);
  endtask

  task automatic step();
    logic [3:0] obs;
    pkt_t       p;
    bit         was_idle;
    @(negedge clock);
    k++;
    obs = observe();
    was_idle = (exp_q.size() == 0);
    if (was_idle) check("idle", {28'd0, obs}, 32'h0000_000E);
    else check("wire", {28'd0, obs}, {28'd0, exp_q.pop_front()});
    if (!prev_frame && obs[2]) check("frame_rise", k, cur_rise);
    prev_frame = obs[2];
    if (was_idle && pkt_q.size() > 0) begin
      p        = pkt_q.pop_front();
      vld      = 1'b1;
      addr     = p.a;
      payload  = p.d;
      lo       = p.lo;
      hi       = p.hi;
      cur_rise = p.rise;
      k        = 0;
      build(p);
    end else begin
      vld     = hold_vld && !was_idle;
      addr    = 4'($urandom);
      payload = $urandom;
    end
    stall = (k >= lo && k <= hi);
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && (pkt_q.size() != 0 || exp_q.size() != 0); n++) step();
    check("drain", pkt_q.size() + exp_q.size(), 0);
    repeat (2) step();
  endtask

  initial begin
    reset_n = 1'b0;
    vld     = 1'b0;
    stall   = 1'b0;
    addr    = 4'd0;
    payload = 32'd0;
    repeat (3) begin
      @(negedge clock);
      check("reset", {28'd0, observe()}, 32'h0000_0006);
    end
    reset_n = 1'b1;

    pkt_q.push_back('{a: 4'h7, d: 32'hA5A5_0F0F, lo: -10, hi: -10, rise: 41});
    pkt_q.push_back('{a: 4'h9, d: 32'h8000_0001, lo: 15, hi: 17, rise: 44});
    pkt_q.push_back('{a: 4'h5, d: 32'h1357_9BDF, lo: 1, hi: 8, rise: 41});
    pkt_q.push_back('{a: 4'hA, d: 32'h0F0F_A5A5, lo: 9, hi: 9, rise: 42});
    pkt_q.push_back('{a: 4'h2, d: 32'hFFFF_0000, lo: 41, hi: 42, rise: 41});
    drain();

    hold_vld = 1'b1;
    pkt_q.push_back('{a: 4'h0, d: 32'h1234_5678, lo: -10, hi: -10, rise: 41});
    pkt_q.push_back('{a: 4'hF, d: 32'hDEAD_BEEF, lo: -10, hi: -10, rise: 41});
    drain();
    hold_vld = 1'b0;

    // Reset lands while payload bit 12 is on the wire (T+22).
    pkt_q.push_back('{a: 4'h3, d: 32'hC3C3_1234, lo: -10, hi: -10, rise: -1});
    for (int n = 0; n < 200 && !(pkt_q.size() == 0 && k == 22); n++) step();
    check("reset_reach", k, 22);
    reset_n = 1'b0;
    vld     = 1'b0;
    stall   = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("reset_mid", {28'd0, observe()}, 32'h0000_0006);
    reset_n    = 1'b1;
    prev_frame = 1'b1;
    pkt_q.push_back('{a: 4'hC, d: 32'h5A5A_C33C, lo: -10, hi: -10, rise: 41});
    drain();

    sel = 1'b1;
    pkt_q.push_back('{a: 4'h6, d: 32'h7E81_0FF0, lo: -10, hi: -10, rise: 37});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
